// File: rtl/pipe_collision_scorer_if.sv
// Bus between the pipe X generator / game top and the collision scorer.
// master drives the frame geometry and handshake inputs; slave is the scorer.
interface pipe_collision_scorer_if;
  logic       Start;
  logic       Ack;
  logic       tick;
  logic [2:0] pipe_idx;
  logic [2:0] coin_idx;
  logic [9:0] pipe_xl;
  logic [9:0] pipe_xr;
  logic [9:0] gap_top;
  logic [9:0] gap_bot;
  logic [9:0] coin_xl;
  logic [9:0] coin_xr;
  logic [9:0] coin_yt;
  logic [9:0] coin_yb;
  logic [9:0] bird_y;
  logic       Stop;
  logic       hit;
  logic       coin_hide;
  logic [9:0] score;
  logic [9:0] coins;
  logic [9:0] best;
  logic       Q_Idle;
  logic       Q_Run;
  logic       Q_Stop;

  modport master (
    output Start, Ack, tick, pipe_idx, coin_idx, pipe_xl, pipe_xr,
           gap_top, gap_bot, coin_xl, coin_xr, coin_yt, coin_yb, bird_y,
    input  Stop, hit, coin_hide, score, coins, best, Q_Idle, Q_Run, Q_Stop
  );

  modport slave (
    input  Start, Ack, tick, pipe_idx, coin_idx, pipe_xl, pipe_xr,
           gap_top, gap_bot, coin_xl, coin_xr, coin_yt, coin_yb, bird_y,
    output Stop, hit, coin_hide, score, coins, best, Q_Idle, Q_Run, Q_Stop
  );
endinterface

// File: rtl/pipe_collision_scorer.sv
// Bird/pipe/floor collision detection, pipe and coin scoring, best-score
// tracking and the Stop/Ack game handshake.
module pipe_collision_scorer #(
  parameter int unsigned BIRD_X    = 200,
  parameter int unsigned BIRD_W    = 30,
  parameter int unsigned BIRD_H    = 24,
  parameter int unsigned FLOOR_Y   = 440,
  parameter int unsigned SCORE_MAX = 999
) (
  input  logic                     clk,
  input  logic                     reset_n,
  pipe_collision_scorer_if.slave   bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_STOP} state_e;

  localparam logic [10:0] BIRD_XL = 11'(BIRD_X);
  localparam logic [10:0] BIRD_XR = 11'(BIRD_X + BIRD_W);
  localparam logic [10:0] BIRD_HH = 11'(BIRD_H);
  localparam logic [10:0] FLOOR   = 11'(FLOOR_Y);
  localparam logic [9:0]  SMAX    = 10'(SCORE_MAX);

  state_e     state_q, state_d;
  logic [9:0] score_q, score_d;
  logic [9:0] coins_q, coins_d;
  logic [9:0] best_q, best_d;
  logic [2:0] prev_pipe_q, prev_pipe_d;
  logic [2:0] prev_coin_q, prev_coin_d;
  logic       coin_hide_q, coin_hide_d;
  logic       hit_q, hit_d;

  logic [10:0] bird_yt, bird_yb;
  logic        pipe_x_ov, pipe_hit, floor_hit, collision, coin_ov;

  // All geometry compared at 11 bits so bird_y + BIRD_H cannot wrap.
  always_comb begin
    bird_yt   = {1'b0, bus.bird_y};
    bird_yb   = bird_yt + BIRD_HH;
    pipe_x_ov = ({1'b0, bus.pipe_xl} < BIRD_XR) && ({1'b0, bus.pipe_xr} > BIRD_XL);
    pipe_hit  = pipe_x_ov &&
                ((bird_yt < {1'b0, bus.gap_top}) || (bird_yb > {1'b0, bus.gap_bot}));
    floor_hit = bird_yb >= FLOOR;
    collision = pipe_hit || floor_hit;
    coin_ov   = ({1'b0, bus.coin_xl} < BIRD_XR) && ({1'b0, bus.coin_xr} > BIRD_XL) &&
                ({1'b0, bus.coin_yt} < bird_yb) && ({1'b0, bus.coin_yb} > bird_yt);
  end

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    coins_d     = coins_q;
    best_d      = best_q;
    prev_pipe_d = prev_pipe_q;
    prev_coin_d = prev_coin_q;
    coin_hide_d = coin_hide_q;
    hit_d       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          state_d     = S_RUN;
          score_d     = '0;
          coins_d     = '0;
          prev_pipe_d = bus.pipe_idx;
          prev_coin_d = bus.coin_idx;
          coin_hide_d = 1'b0;
        end
      end
      S_RUN: begin
        if (bus.tick) begin
          if (collision) begin
            state_d = S_STOP;
            hit_d   = 1'b1;
            best_d  = (score_q > best_q) ? score_q : best_q;
          end else begin
            if (bus.pipe_idx != prev_pipe_q) begin
              prev_pipe_d = bus.pipe_idx;
              if (score_q < SMAX) score_d = score_q + 10'd1;
            end
            // A fresh coin index only re-arms collection; taking waits a tick.
            if (bus.coin_idx != prev_coin_q) begin
              prev_coin_d = bus.coin_idx;
              coin_hide_d = 1'b0;
            end else if (!coin_hide_q && coin_ov) begin
              coin_hide_d = 1'b1;
              if (coins_q < SMAX) coins_d = coins_q + 10'd1;
            end
          end
        end
      end
      S_STOP: begin
        if (bus.Ack) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      score_q     <= '0;
      coins_q     <= '0;
      best_q      <= '0;
      prev_pipe_q <= '0;
      prev_coin_q <= '0;
      coin_hide_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      coins_q     <= coins_d;
      best_q      <= best_d;
      prev_pipe_q <= prev_pipe_d;
      prev_coin_q <= prev_coin_d;
      coin_hide_q <= coin_hide_d;
      hit_q       <= hit_d;
    end
  end

  assign bus.Stop      = (state_q == S_STOP);
  assign bus.hit       = hit_q;
  assign bus.coin_hide = coin_hide_q;
  assign bus.score     = score_q;
  assign bus.coins     = coins_q;
  assign bus.best      = best_q;
  assign bus.Q_Idle    = (state_q == S_IDLE);
  assign bus.Q_Run     = (state_q == S_RUN);
  assign bus.Q_Stop    = (state_q == S_STOP);

endmodule

// File: tb/tb_pipe_collision_scorer.sv
// Directed scenario bench for pipe_collision_scorer with hand-computed expectations.
module tb_pipe_collision_scorer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int unsigned tests = 0;
  int unsigned fails = 0;

  pipe_collision_scorer_if bus ();

  pipe_collision_scorer #(
    .BIRD_X(200), .BIRD_W(30), .BIRD_H(24), .FLOOR_Y(440), .SCORE_MAX(999)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_tick();
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
  endtask

  task automatic pipe_far();
    bus.pipe_xl = 10'd500;
    bus.pipe_xr = 10'd561;
  endtask

  task automatic test_reset();
    bus.Start = 0; bus.Ack = 0; bus.tick = 0;
    bus.pipe_idx = 0; bus.coin_idx = 0;
    pipe_far();
    bus.gap_top = 10'd150; bus.gap_bot = 10'd250;
    bus.coin_xl = 10'd600; bus.coin_xr = 10'd620;
    bus.coin_yt = 10'd0;   bus.coin_yb = 10'd20;
    bus.bird_y = 10'd200;
    reset_n = 0;
    step(); step();
    reset_n = 1;
    tests++; if (bus.Q_Idle !== 1'b1) begin fails++; $display("FAIL reset_q_idle got %0d exp 1", bus.Q_Idle); end
    tests++; if (bus.Stop !== 1'b0) begin fails++; $display("FAIL reset_stop got %0d exp 0", bus.Stop); end
    tests++; if (bus.hit !== 1'b0) begin fails++; $display("FAIL reset_hit got %0d exp 0", bus.hit); end
    tests++; if (bus.coin_hide !== 1'b0) begin fails++; $display("FAIL reset_coin_hide got %0d exp 0", bus.coin_hide); end
    tests++; if (bus.score !== 10'd0 || bus.coins !== 10'd0 || bus.best !== 10'd0) begin
      fails++; $display("FAIL reset_counters got %0d/%0d/%0d exp 0/0/0", bus.score, bus.coins, bus.best); end
  endtask

  task automatic test_start();
    bus.pipe_idx = 3'd2;
    bus.Start = 1; step(); bus.Start = 0;
    tests++; if (bus.Q_Run !== 1'b1) begin fails++; $display("FAIL start_q_run got %0d exp 1", bus.Q_Run); end
    tests++; if (bus.Stop !== 1'b0) begin fails++; $display("FAIL start_stop got %0d exp 0", bus.Stop); end
    tests++; if (bus.score !== 10'd0 || bus.coins !== 10'd0) begin
      fails++; $display("FAIL start_counters got %0d/%0d exp 0/0", bus.score, bus.coins); end
  endtask

  task automatic test_pipe_score();
    bus.pipe_xl = 10'd100; bus.pipe_xr = 10'd161; bus.bird_y = 10'd200;
    do_tick();
    tests++; if (bus.hit !== 1'b0 || bus.Q_Run !== 1'b1) begin
      fails++; $display("FAIL no_overlap got hit=%0d run=%0d exp 0/1", bus.hit, bus.Q_Run); end
    bus.pipe_idx = 3'd3; do_tick();
    tests++; if (bus.score !== 10'd1) begin fails++; $display("FAIL score_inc got %0d exp 1", bus.score); end
    do_tick();
    tests++; if (bus.score !== 10'd1) begin fails++; $display("FAIL score_hold got %0d exp 1", bus.score); end
  endtask

  task automatic ack_restart();
    bus.Ack = 1; step(); bus.Ack = 0;
    tests++; if (bus.Q_Idle !== 1'b1) begin fails++; $display("FAIL ack_idle got %0d exp 1", bus.Q_Idle); end
    bus.Start = 1; step(); bus.Start = 0;
  endtask

  task automatic test_pipe_hit();
    bus.pipe_xl = 10'd220; bus.pipe_xr = 10'd281;
    bus.gap_top = 10'd150; bus.gap_bot = 10'd250; bus.bird_y = 10'd140;
    do_tick();
    tests++; if (bus.hit !== 1'b1 || bus.Stop !== 1'b1) begin
      fails++; $display("FAIL gap_top_hit got hit=%0d stop=%0d exp 1/1", bus.hit, bus.Stop); end
    tests++; if (bus.best !== 10'd1) begin fails++; $display("FAIL best_latch got %0d exp 1", bus.best); end
    do_tick();
    tests++; if (bus.hit !== 1'b0 || bus.Q_Stop !== 1'b1) begin
      fails++; $display("FAIL hit_pulse got hit=%0d stop=%0d exp 0/1", bus.hit, bus.Q_Stop); end
    ack_restart();
    // pipe_xl == BIRD_X+BIRD_W is no overlap even with bird above the gap
    bus.pipe_xl = 10'd230; do_tick();
    tests++; if (bus.hit !== 1'b0 || bus.Q_Run !== 1'b1) begin
      fails++; $display("FAIL xl_boundary got hit=%0d run=%0d exp 0/1", bus.hit, bus.Q_Run); end
    bus.pipe_xl = 10'd220;
    bus.bird_y = 10'd150; do_tick();
    tests++; if (bus.hit !== 1'b0) begin fails++; $display("FAIL gap_top_edge got %0d exp 0", bus.hit); end
    bus.bird_y = 10'd226; do_tick();
    tests++; if (bus.hit !== 1'b0) begin fails++; $display("FAIL gap_bot_edge got %0d exp 0", bus.hit); end
    bus.bird_y = 10'd227; do_tick();
    tests++; if (bus.hit !== 1'b1 || bus.Stop !== 1'b1) begin
      fails++; $display("FAIL gap_bot_hit got hit=%0d stop=%0d exp 1/1", bus.hit, bus.Stop); end
    tests++; if (bus.best !== 10'd1 || bus.score !== 10'd0) begin
      fails++; $display("FAIL best_keep got best=%0d score=%0d exp 1/0", bus.best, bus.score); end
    ack_restart();
  endtask

  task automatic test_floor();
    pipe_far();
    bus.bird_y = 10'd415; do_tick();
    tests++; if (bus.hit !== 1'b0) begin fails++; $display("FAIL floor_above got %0d exp 0", bus.hit); end
    bus.bird_y = 10'd416; do_tick();
    tests++; if (bus.hit !== 1'b1 || bus.Stop !== 1'b1) begin
      fails++; $display("FAIL floor_hit got hit=%0d stop=%0d exp 1/1", bus.hit, bus.Stop); end
    // tick and Start are ignored while stopped
    bus.Start = 1; bus.pipe_idx = 3'd4; do_tick(); bus.Start = 0; bus.pipe_idx = 3'd3;
    tests++; if (bus.Q_Stop !== 1'b1 || bus.score !== 10'd0) begin
      fails++; $display("FAIL stop_ignore got stop=%0d score=%0d exp 1/0", bus.Q_Stop, bus.score); end
    bus.bird_y = 10'd200;
    ack_restart();
    tests++; if (bus.score !== 10'd0 || bus.best !== 10'd1 || bus.Q_Run !== 1'b1) begin
      fails++; $display("FAIL restart got score=%0d best=%0d run=%0d exp 0/1/1", bus.score, bus.best, bus.Q_Run); end
  endtask

  task automatic test_coin();
    bus.coin_xl = 10'd210; bus.coin_xr = 10'd230;
    bus.coin_yt = 10'd210; bus.coin_yb = 10'd230;
    do_tick();
    tests++; if (bus.coins !== 10'd1 || bus.coin_hide !== 1'b1) begin
      fails++; $display("FAIL coin_take got coins=%0d hide=%0d exp 1/1", bus.coins, bus.coin_hide); end
    do_tick(); do_tick();
    tests++; if (bus.coins !== 10'd1) begin fails++; $display("FAIL coin_once got %0d exp 1", bus.coins); end
    bus.coin_idx = 3'd1; do_tick();
    tests++; if (bus.coin_hide !== 1'b0 || bus.coins !== 10'd1) begin
      fails++; $display("FAIL coin_rearm got hide=%0d coins=%0d exp 0/1", bus.coin_hide, bus.coins); end
    bus.pipe_idx = 3'd4; do_tick();
    tests++; if (bus.coins !== 10'd2 || bus.score !== 10'd1) begin
      fails++; $display("FAIL score_and_coin got coins=%0d score=%0d exp 2/1", bus.coins, bus.score); end
  endtask

  task automatic test_collision_priority();
    bus.pipe_idx = 3'd0; bus.coin_idx = 3'd2;
    bus.pipe_xl = 10'd220; bus.pipe_xr = 10'd281; bus.bird_y = 10'd140;
    do_tick();
    tests++; if (bus.Q_Stop !== 1'b1 || bus.score !== 10'd1 || bus.coins !== 10'd2) begin
      fails++; $display("FAIL collide_wins got stop=%0d score=%0d coins=%0d exp 1/1/2", bus.Q_Stop, bus.score, bus.coins); end
    tests++; if (bus.coin_hide !== 1'b1) begin fails++; $display("FAIL collide_hide got %0d exp 1", bus.coin_hide); end
    pipe_far(); bus.bird_y = 10'd200;
    bus.coin_xl = 10'd600; bus.coin_xr = 10'd620; bus.coin_yt = 10'd0; bus.coin_yb = 10'd20;
    ack_restart();
  endtask

  task automatic test_saturation();
    for (int i = 1; i <= 1000; i++) begin
      bus.pipe_idx = (i % 2 == 1) ? 3'd1 : 3'd0;
      do_tick();
      if (i == 999) begin
        tests++; if (bus.score !== 10'd999) begin fails++; $display("FAIL score_reach got %0d exp 999", bus.score); end
      end
    end
    tests++; if (bus.score !== 10'd999) begin fails++; $display("FAIL score_sat got %0d exp 999", bus.score); end
    bus.bird_y = 10'd430; do_tick();
    tests++; if (bus.best !== 10'd999) begin fails++; $display("FAIL best_999 got %0d exp 999", bus.best); end
    bus.bird_y = 10'd200;
    ack_restart();
  endtask

  task automatic test_reset_mid_run();
    bus.pipe_idx = 3'd1; do_tick();
    bus.coin_xl = 10'd210; bus.coin_xr = 10'd230; bus.coin_yt = 10'd210; bus.coin_yb = 10'd230;
    do_tick();
    tests++; if (bus.score !== 10'd1 || bus.coins !== 10'd1) begin
      fails++; $display("FAIL pre_reset got score=%0d coins=%0d exp 1/1", bus.score, bus.coins); end
    reset_n = 0; step(); reset_n = 1;
    tests++; if (bus.Q_Idle !== 1'b1 || bus.Q_Run !== 1'b0 || bus.Stop !== 1'b0) begin
      fails++; $display("FAIL midrun_state got idle=%0d run=%0d stop=%0d exp 1/0/0", bus.Q_Idle, bus.Q_Run, bus.Stop); end
    tests++; if (bus.score !== 10'd0 || bus.coins !== 10'd0 || bus.best !== 10'd0 || bus.coin_hide !== 1'b0 || bus.hit !== 1'b0) begin
      fails++; $display("FAIL midrun_outputs got %0d/%0d/%0d/%0d/%0d exp all 0", bus.score, bus.coins, bus.best, bus.coin_hide, bus.hit); end
  endtask

  initial begin
    test_reset();
    test_start();
    test_pipe_score();
    test_pipe_hit();
    test_floor();
    test_coin();
    test_collision_priority();
    test_saturation();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pipe_collision_scorer.md
Name: pipe_collision_scorer

Overview:
- Consumes the current in-scope pipe and coin coordinates that the pipe X generator drives each frame, plus the gap Y values and the bird position.
- Detects bird/pipe and bird/floor collisions, counts pipes passed and coins collected, and tracks a best score.
- Drives the Stop/Ack handshake back to the pipe X generator and the game top level.
- Sits between the pipe X generator and the VGA renderer/score display.

Parameters:
- BIRD_X, 200, bird left edge X (fixed column).
- BIRD_W, 30, bird width; bird spans X in [BIRD_X, BIRD_X+BIRD_W).
- BIRD_H, 24, bird height.
- FLOOR_Y, 440, bird bottom at or below this row is a floor hit.
- SCORE_MAX, 999, score and coin counters saturate here.

Ports:
- clk  in  1  system clock, same as the pipe X generator.
- reset_n  in  1  synchronous, active-low reset.
- Start  in  1  game start request, sampled in IDLE only.
- Ack  in  1  game-over acknowledge, sampled in STOP only.
- tick  in  1  one-cycle strobe, coincident with each 1-pixel pipe shift.
- pipe_idx  in  3  index of the current in-scope pipe (0..4).
- coin_idx  in  3  index of the current in-scope coin (0..4).
- pipe_xl, pipe_xr  in  10 each  current pipe left and right X.
- gap_top, gap_bot  in  10 each  current pipe gap top and bottom Y.
- coin_xl, coin_xr  in  10 each  current coin left and right X.
- coin_yt, coin_yb  in  10 each  current coin top and bottom Y.
- bird_y  in  10  bird top Y.
- Stop  out  1  level; high in STOP state.
- hit  out  1  one-cycle pulse on collision detection.
- coin_hide  out  1  current coin has been collected; renderer suppresses it.
- score  out  10  pipes passed.
- coins  out  10  coins collected.
- best  out  10  best score since reset.
- Q_Idle, Q_Run, Q_Stop  out  1 each  one-hot state.

Behaviour:
- Reset (reset_n=0 at posedge): state IDLE, Stop=0, hit=0, coin_hide=0, score=0, coins=0, best=0. Reset mid-game aborts with no best update.
- States:
  - IDLE: Start=1 -> RUN. On that same edge: clear score and coins, latch prev_pipe=pipe_idx and prev_coin=coin_idx, clear coin_hide.
  - RUN: on a tick cycle, if collision -> STOP. Start is ignored.
  - STOP: Stop=1. Ack=1 -> IDLE. tick and Start are ignored.
- All arithmetic is done at 11 bits so sums cannot overflow.
- Collision is the OR of:
  - pipe hit: X overlap (pipe_xl < BIRD_X+BIRD_W AND pipe_xr > BIRD_X) AND (bird_y < gap_top OR bird_y+BIRD_H > gap_bot);
  - floor hit: bird_y+BIRD_H >= FLOOR_Y.
- Edge cases at exact boundaries:
  - pipe_xl == BIRD_X+BIRD_W is no overlap.
  - bird_y == gap_top is a pass.
- Inputs are evaluated only in RUN on tick=1. Inputs are assumed stable for the tick cycle.
- Collision response:
  - hit pulses 1 cycle and the state moves to STOP on the same edge, so Stop is high in the cycle after the tick.
  - On that edge, best <= max(best, score).
- Pipe scoring (RUN, tick=1, no collision): if pipe_idx != prev_pipe, score += 1 (saturating at SCORE_MAX) and prev_pipe <= pipe_idx. An index change counts once even if it jumped by more than 1.
- Coin collection (RUN, tick=1, no collision):
  - If coin_idx != prev_coin: prev_coin <= coin_idx and coin_hide <= 0. This takes priority over a take in the same cycle; the new coin can be taken from the next tick.
  - Else, if coin_hide=0 and the bird box overlaps the coin box (strict inequalities on all four sides): coins += 1 (saturating) and coin_hide <= 1.
- Simultaneous events:
  - Collision on the same tick as a score or coin event: collision wins; score and coins are not incremented.
  - Pipe score and coin take on the same tick are both applied.
- Counters hold their values in STOP and IDLE until the next Start.
- best is only written on entry to STOP.

Test Plan:
- Reset, then Start=1 with pipe_idx=2 -> Q_Run=1, score=0, coins=0, Stop=0.
- RUN, tick with pipe_xl=100, pipe_xr=161, bird_y=200 -> no X overlap, no hit. Next tick pipe_idx=3 -> score=1. Tick with pipe_idx unchanged -> score stays 1.
- pipe_xl=220, pipe_xr=281, gap_top=150, gap_bot=250, bird_y=140, tick -> hit pulse, Stop=1 next cycle, best=current score. Repeat with bird_y=150 -> no hit. Repeat with bird_y=226 (bottom 250) -> no hit. Repeat with bird_y=227 -> hit.
- bird_y=416, no pipe overlap, tick -> floor hit -> STOP. Then Ack=1 -> IDLE. Then Start -> score=0 while best is retained.
- Coin box (210..230, 210..230), bird_y=200, tick -> coins=1, coin_hide=1. Further overlapping ticks -> coins stays 1. coin_idx change -> coin_hide=0.
- Pipe index change and collision on the same tick -> score unchanged, STOP. Force score=999 and pass another pipe -> score stays 999. Assert reset_n=0 mid-RUN -> all outputs 0 and IDLE next cycle.
